// File: rtl/booth_radix4_mac_if.sv
// Operand/result bundle for booth_radix4_mac. The master drives the operands and
// the slave (the MAC) returns ready, the result pulse and the accumulator.
interface booth_radix4_mac_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     a;
  logic signed [WIDTH-1:0]     b;
  logic                        acc_clear;
  logic                        out_valid;
  logic signed [ACC_WIDTH-1:0] acc_out;

  modport master (
    output in_valid, a, b, acc_clear,
    input  in_ready, out_valid, acc_out
  );

  modport slave (
    input  in_valid, a, b, acc_clear,
    output in_ready, out_valid, acc_out
  );
endinterface

// File: rtl/booth_radix4_mac.sv
// Sequential radix-4 Booth multiply-accumulate: two multiplier bits per cycle into a
// signed accumulator. Define MAC_SAT_EN to saturate the accumulate add instead of wrapping.
module booth_radix4_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  booth_radix4_mac_if.slave bus
);
  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int KW    = $clog2(STEPS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                      state_q, state_d;
  logic signed [WIDTH-1:0]     a_q, a_d;
  logic signed [WIDTH:0]       w_q, w_d;
  logic signed [PW-1:0]        p_q, p_d;
  logic [KW-1:0]               k_q, k_d;
  logic                        clr_q, clr_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;

  logic                        in_ready;
  logic                        accept;
  logic                        last_step;
  logic                        booth_zero, booth_shift, booth_neg;
  logic signed [PW-1:0]        a_ext, pp_mag, pp, pp_shifted, p_sum;
  logic signed [ACC_WIDTH-1:0] pf_ext, acc_sum;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  assign accept    = bus.in_valid && in_ready;
  assign last_step = (state_q == RUN) && (k_q == KW'(STEPS - 1));

  // Booth window decode and partial-product selection for the current digit.
  always_comb begin
    booth_zero  = (w_q[2:0] == 3'b000) || (w_q[2:0] == 3'b111);
    booth_shift = (w_q[2:0] == 3'b011) || (w_q[2:0] == 3'b100);
    booth_neg   = w_q[2] && (w_q[2:0] != 3'b111);
    a_ext       = PW'(a_q);
    pp_mag      = booth_zero ? '0 : (booth_shift ? (a_ext <<< 1) : a_ext);
    pp          = booth_neg ? -pp_mag : pp_mag;
    pp_shifted  = pp <<< {k_q, 1'b0};
    p_sum       = p_q + pp_shifted;
    pf_ext      = ACC_WIDTH'(p_sum);
  end

`ifdef MAC_SAT_EN
  logic signed [ACC_WIDTH:0] sum_wide;
  logic                      overflow;

  // Same-sign operands whose wide sum leaves the ACC_WIDTH range clamp to the nearest limit.
  always_comb begin
    sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {pf_ext[ACC_WIDTH-1], pf_ext};
    overflow = (acc_q[ACC_WIDTH-1] == pf_ext[ACC_WIDTH-1]) &&
               (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]);
    if (!overflow)              acc_sum = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH]) acc_sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else                        acc_sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    acc_sum = acc_q + pf_ext;
  end
`endif

  always_comb begin
    a_d         = a_q;
    w_d         = w_q;
    p_d         = p_q;
    k_d         = k_q;
    clr_d       = clr_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    if (accept) begin
      a_d   = bus.a;
      w_d   = {bus.b, 1'b0};
      p_d   = '0;
      k_d   = '0;
      clr_d = bus.acc_clear;
    end else if (state_q == RUN) begin
      p_d = p_sum;
      w_d = w_q >>> 2;
      k_d = k_q + KW'(1);
      if (last_step) begin
        acc_d       = clr_q ? pf_ext : acc_sum;
        out_valid_d = 1'b1;
      end
    end
  end

  // Only the architecturally visible result state is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: operand, window, product and step registers are rewritten on every acceptance
  // before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    w_q   <= w_d;
    p_q   <= p_d;
    k_q   <= k_d;
    clr_q <= clr_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;

endmodule

// File: tb/tb_booth_radix4_mac.sv
// Directed and sampled-random bench for booth_radix4_mac with a result scoreboard;
// a second instance with a 16-bit accumulator exercises the wrap/saturate corner.
module tb_booth_radix4_mac;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_radix4_mac_if #(.WIDTH(W), .ACC_WIDTH(32)) bus   ();
  booth_radix4_mac_if #(.WIDTH(W), .ACC_WIDTH(16)) bus16 ();

  booth_radix4_mac #(.WIDTH(W), .ACC_WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
  booth_radix4_mac #(.WIDTH(W), .ACC_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    longint acc;
    int     due;
  } exp_t;

  exp_t   q32[$];
  exp_t   q16[$];
  int     n_cmp   = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  longint model32 = 0;
  longint model16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint acc_model(input longint acc, input longint p,
                                       input bit clr, input int aw);
    longint s, lo, hi, m;
    lo = -(longint'(1) <<< (aw - 1));
    hi = (longint'(1) <<< (aw - 1)) - 1;
    m  = longint'(1) <<< aw;
    if (clr) return p;
    s = acc + p;
`ifdef MAC_SAT_EN
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
`else
    s = (((s - lo) % m) + m) % m + lo;
`endif
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic signed [W-1:0] ta, input logic signed [W-1:0] tbv,
                       input logic tclr, input bit expect_out, output int acc_cyc);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("in_ready_timeout", 0, 1);
    bus.a = ta; bus.b = tbv; bus.acc_clear = tclr; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    if (expect_out) begin
      model32 = acc_model(model32, longint'(ta) * longint'(tbv), tclr, 32);
      q32.push_back('{model32, cyc + W / 2});
    end
  endtask

  task automatic issue16(input logic signed [W-1:0] ta, input logic signed [W-1:0] tbv,
                         input logic tclr);
    int waited = 0;
    while (bus16.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("in_ready16_timeout", 0, 1);
    bus16.a = ta; bus16.b = tbv; bus16.acc_clear = tclr; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    model16 = acc_model(model16, longint'(ta) * longint'(tbv), tclr, 16);
    q16.push_back('{model16, cyc + W / 2});
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("idle_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (q32.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        e = q32.pop_front();
        check("acc_out", bus.acc_out, e.acc);
        check("latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16.out_valid === 1'b1) begin
      if (q16.size() == 0) check("unexpected_out_valid16", 1, 0);
      else begin
        e = q16.pop_front();
        check("acc_out16", bus16.acc_out, e.acc);
        check("latency16", cyc, e.due);
      end
    end
  end

  initial begin
    int t0, t1, t2, t3;
    int waited;
    logic signed [W-1:0] ra, rb;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.acc_clear = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.acc_clear = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_acc_out",   bus.acc_out,   0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_in_ready",  bus.in_ready,  1);
    end

    // Basic multiply; in_valid pulses during RUN must be ignored.
    issue(8'sd7, 8'sd3, 1'b1, 1'b1, t0);
    for (int i = 0; i < 3; i++) begin
      check("run_in_ready", bus.in_ready, 0);
      check("run_acc_hold", bus.acc_out, 0);
      bus.a = 8'sd100; bus.b = 8'sd100; bus.acc_clear = 1'b1; bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle();
    check("basic_7x3", bus.acc_out, 21);

    // Signed corners, back-to-back in the out_valid cycle.
    issue(-8'sd128, -8'sd128, 1'b1, 1'b1, t1);
    issue(-8'sd1,    8'sd1,   1'b0, 1'b1, t2);
    issue( 8'sd127, -8'sd128, 1'b0, 1'b1, t3);
    check("b2b_accept_1", t2, t1 + W / 2 + 1);
    check("b2b_accept_2", t3, t2 + W / 2 + 1);
    wait_idle();
    check("corner_final", bus.acc_out, 127);

    // Zero and shift windows, then sampled sweeps.
    issue(8'sd5, 8'sd0, 1'b1, 1'b1, t0);
    wait_idle();
    check("b_zero", bus.acc_out, 0);
    issue(8'sd5, -8'sd86, 1'b1, 1'b1, t0);
    wait_idle();
    check("b_0xAA", bus.acc_out, -430);
    for (int i = -128; i < 128; i++) begin
      ra = W'(i);
      issue(ra, W'($urandom), 1'($urandom), 1'b1, t0);
    end
    for (int i = -128; i < 128; i++) begin
      rb = W'(i);
      issue(-8'sd128, rb, 1'b1, 1'b1, t0);
      issue( 8'sd127, rb, 1'b0, 1'b1, t0);
    end
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      issue(ra, rb, 1'($urandom), 1'b1, t0);
    end
    wait_idle();

    // Reset during the second RUN cycle aborts the operation.
    issue(8'sd9, 8'sd9, 1'b1, 1'b0, t0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model32 = 0;
    for (int i = 0; i < 6; i++) begin
      check("abort_acc_out",   bus.acc_out,   0);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_in_ready",  bus.in_ready,  1);
      @(negedge clk);
    end
    issue(8'sd2, 8'sd3, 1'b0, 1'b1, t0);
    wait_idle();
    check("after_abort", bus.acc_out, 6);

    // Reset together with in_valid accepts nothing.
    bus.a = 8'sd50; bus.b = 8'sd50; bus.acc_clear = 1'b1; bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model32 = 0;
    for (int i = 0; i < 6; i++) begin
      check("rst_valid_in_ready", bus.in_ready, 1);
      check("rst_valid_acc_out",  bus.acc_out,  0);
      @(negedge clk);
    end

    // 16-bit accumulator overflow corner.
    issue16(8'sd127, 8'sd127, 1'b1);
    issue16(8'sd127, 8'sd127, 1'b0);
    issue16(8'sd127, 8'sd127, 1'b0);
    waited = 0;
    while (bus16.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("idle16_timeout", 0, 1);
`ifdef MAC_SAT_EN
    check("acc16_third", bus16.acc_out, 32767);
`else
    check("acc16_third", bus16.acc_out, -17149);
`endif

    waited = 0;
    while ((q32.size() != 0 || q16.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", q32.size() + q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
